vec_pair_serializer: RTL and testbench

- Downstream consumer of the top-level per-lane bit-pair vectors (o_a/o_b, SIZE bits each, one capture per clock).
- Buffers captured vector pairs in a small FIFO and serializes each pair LSB-first onto a 2-bit stream with a valid/ready handshake.
- Producer has no backpressure: words arriving while full are dropped and flagged sticky.

---
 rtl/vec_pair_serializer.sv | 184 ++++++++++++++++++
 tb/tb_vec_pair_serializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_pair_serializer.sv
// -----------------------------------------------------------------------------
// vec_pair_serializer
//
// Captures pairs of SIZE-bit lane vectors (i_a/i_b) into a DEPTH-entry FIFO
// and replays each pair LSB-first as a 2-bit stream under a valid/ready
// handshake. The producer cannot be stalled. A word that arrives while the
// FIFO is full is dropped, and the sticky o_overflow flag is set.
//
// Ports:
//   i_clk        clock; all state changes on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_a, i_b     lane-a / lane-b vectors to capture
//   i_valid      capture request for i_a/i_b this cycle
//   o_ready      FIFO not full (from the registered count only)
//   o_bit_a/b    current serialized lane-a / lane-b bit
//   o_bit_valid  o_bit_a/o_bit_b/o_idx/o_last are valid
//   i_bit_ready  sink accepts the current bit pair
//   o_idx        lane index of the current bit pair
//   o_last       current bit pair is lane SIZE-1
//   o_count      FIFO occupancy, excluding the word in the shift stage
//   o_overflow   sticky: at least one word was dropped since reset
// -----------------------------------------------------------------------------
module vec_pair_serializer #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [SIZE-1:0]            i_a,
  input  logic [SIZE-1:0]            i_b,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic                       o_bit_a,
  output logic                       o_bit_b,
  output logic                       o_bit_valid,
  input  logic                       i_bit_ready,
  output logic [$clog2(SIZE)-1:0]    o_idx,
  output logic                       o_last,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow
);

  localparam int IW = $clog2(SIZE);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W  = 2 * SIZE;

  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [W-1:0]    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [SIZE-1:0] r_sa;
  logic [SIZE-1:0] r_sb;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_next;
  logic            r_overflow;

  logic            w_push;
  logic            w_pop;
  logic            w_fifo_nonempty;

  // Full is decided from the registered count, so a pop in the same cycle
  // does not free a slot for a push.
  assign o_ready         = (r_count != FULL_CNT);
  assign w_push          = i_valid && o_ready;
  assign w_fifo_nonempty = (r_count != '0);

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is assigned with <= so that every register in
    // this module samples values from before the edge.
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, pop decision and stream outputs.
  always_comb begin
    // NOTE: every output of this block is given a default first. This
    // prevents any path from leaving a signal unassigned, which would infer
    // a latch.
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_pop        = 1'b0;
    o_bit_valid  = 1'b0;
    o_bit_a      = 1'b0;
    o_bit_b      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_fifo_nonempty) begin
          w_pop        = 1'b1;
          w_idx_next   = '0;
          w_state_next = S_SHIFT;
        end
      end

      S_SHIFT: begin
        o_bit_valid = 1'b1;
        o_bit_a     = r_sa[r_idx];
        o_bit_b     = r_sb[r_idx];
        // Without acceptance, everything holds.
        if (i_bit_ready) begin
          if (r_idx != LAST_IDX) begin
            w_idx_next = r_idx + IW'(1);
          end else if (w_fifo_nonempty) begin
            // Chain straight into the next word; no idle beat between words.
            w_pop      = 1'b1;
            w_idx_next = '0;
          end else begin
            w_idx_next   = '0;
            w_state_next = S_IDLE;
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_idx      = r_idx;
  assign o_last     = o_bit_valid && (r_idx == LAST_IDX);
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // FIFO storage.
  always_ff @(posedge i_clk) begin
    // NOTE: the storage array has no reset. An entry is read only after it
    // has been written, because reads are gated by the reset-cleared count.
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_b, i_a};
    end
  end

  // FIFO pointers and occupancy. The pointers wrap at DEPTH (a power of 2).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Shift stage and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sa       <= '0;
      r_sb       <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        {r_sb, r_sa} <= r_mem[r_rd_ptr];
      end
      r_idx <= w_idx_next;
      if (i_valid && !o_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vec_pair_serializer.sv
// -----------------------------------------------------------------------------
// tb_vec_pair_serializer
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model (a queue of waiting words, the word being streamed, and a
// beat number) predicts every output on every cycle. Delivered words are also
// compared against constants.
// -----------------------------------------------------------------------------
module tb_vec_pair_serializer;

  localparam int SIZE  = 8;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            i_rst_n;
  logic [SIZE-1:0] i_a, i_b;
  logic            i_valid;
  logic            o_ready;
  logic            o_bit_a, o_bit_b, o_bit_valid;
  logic            i_bit_ready;
  logic [2:0]      o_idx;
  logic            o_last;
  logic [1:0]      o_count;
  logic            o_overflow;

  always #5 clk = ~clk;

  vec_pair_serializer #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_bit_a     (o_bit_a),
    .o_bit_b     (o_bit_b),
    .o_bit_valid (o_bit_valid),
    .i_bit_ready (i_bit_ready),
    .o_idx       (o_idx),
    .o_last      (o_last),
    .o_count     (o_count),
    .o_overflow  (o_overflow)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  logic [2*SIZE-1:0] m_q[$];
  logic              m_have = 1'b0;
  logic [2*SIZE-1:0] m_cur  = '0;
  int                m_beat = 0;
  logic              m_ovf  = 1'b0;

  // Words the sink has fully received, as {b, a}.
  logic [SIZE-1:0]   cap_a, cap_b;
  logic [2*SIZE-1:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    check("bit_valid", 32'(o_bit_valid), 32'(m_have));
    check("bit_a",     32'(o_bit_a),     m_have ? 32'(m_cur[m_beat])      : 32'd0);
    check("bit_b",     32'(o_bit_b),     m_have ? 32'(m_cur[SIZE+m_beat]) : 32'd0);
    check("idx",       32'(o_idx),       m_have ? 32'(m_beat)             : 32'd0);
    check("last",      32'(o_last),      32'(m_have && m_beat == SIZE-1));
    check("count",     32'(o_count),     32'(m_q.size()));
    check("ready",     32'(o_ready),     32'(m_q.size() < DEPTH));
    check("overflow",  32'(o_overflow),  32'(m_ovf));
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit rdy;
    if (!i_rst_n) begin
      m_q.delete();
      m_have = 1'b0;
      m_beat = 0;
      m_ovf  = 1'b0;
    end else begin
      rdy = (m_q.size() < DEPTH);
      if (m_have) begin
        if (i_bit_ready) begin
          if (m_beat < SIZE-1) begin
            m_beat++;
          end else if (m_q.size() > 0) begin
            m_cur  = m_q.pop_front();
            m_beat = 0;
          end else begin
            m_have = 1'b0;
            m_beat = 0;
          end
        end
      end else if (m_q.size() > 0) begin
        m_cur  = m_q.pop_front();
        m_have = 1'b1;
        m_beat = 0;
      end
      if (i_valid) begin
        if (rdy) m_q.push_back({i_b, i_a});
        else     m_ovf = 1'b1;
      end
    end
  endtask

  // Check the outputs at the falling edge, record accepted beats, then cross
  // one rising edge.
  task automatic tick();
    check_outputs();
    if (o_bit_valid === 1'b1 && i_bit_ready) begin
      cap_a[o_idx] = o_bit_a;
      cap_b[o_idx] = o_bit_b;
      if (o_last) got_q.push_back({cap_b, cap_a});
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                       input logic r);
    i_valid     = v;
    i_a         = a;
    i_b         = b;
    i_bit_ready = r;
  endtask

  task automatic wait_for_idx(input int k);
    int n = 0;
    while (!(o_bit_valid === 1'b1 && o_idx == k) && n < 60) begin
      tick();
      n++;
    end
    check($sformatf("reach_idx%0d", k), 32'(o_bit_valid === 1'b1 && o_idx == k), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    drive(1'b0, '0, '0, 1'b1);
    while ((o_bit_valid !== 1'b0 || o_count != 0) && n < 100) begin
      tick();
      n++;
    end
    check("drain_done", 32'(o_bit_valid === 1'b0 && o_count == 0), 32'd1);
  endtask

  initial begin
    int run;
    drive(1'b0, '0, '0, 1'b1);
    i_rst_n = 1'b0;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Single word A5/3C: valid two edges after the push, then 8 beats.
    got_q.delete();
    drive(1'b1, 8'hA5, 8'h3C, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    check("lat_edge1_valid", 32'(o_bit_valid), 32'd0);
    tick();
    check("lat_edge2_valid", 32'(o_bit_valid), 32'd1);
    check("lat_edge2_idx",   32'(o_idx),       32'd0);
    repeat (10) tick();
    check("single_words", 32'(got_q.size()), 32'd1);
    check("single_word0", 32'(got_q[0]),     32'h3CA5);

    // Back-to-back words stream with no gap.
    got_q.delete();
    drive(1'b1, 8'hFF, 8'h00, 1'b1);
    tick();
    drive(1'b1, 8'h00, 8'hFF, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    run = 0;
    while (o_bit_valid === 1'b1 && run < 40) begin
      run++;
      tick();
    end
    check("b2b_run",   32'(run),      32'd16);
    check("b2b_word0", 32'(got_q[0]), 32'h00FF);
    check("b2b_word1", 32'(got_q[1]), 32'hFF00);

    // Backpressure for 3 cycles at lane 3.
    got_q.delete();
    drive(1'b1, 8'h81, 8'h81, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    wait_for_idx(3);
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) tick();
    check("bp_hold_idx", 32'(o_idx), 32'd3);
    drain();
    check("bp_word", 32'(got_q[0]), 32'h8181);

    // Overflow: four words while the sink stalls.
    got_q.delete();
    drive(1'b1, 8'h22, 8'h11, 1'b0); tick();
    drive(1'b1, 8'h44, 8'h33, 1'b0); tick();
    drive(1'b1, 8'h66, 8'h55, 1'b0); tick();
    drive(1'b1, 8'h88, 8'h77, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0);
    check("ovf_count", 32'(o_count),    32'd2);
    check("ovf_ready", 32'(o_ready),    32'd0);
    check("ovf_flag",  32'(o_overflow), 32'd1);
    drain();
    check("ovf_words", 32'(got_q.size()), 32'd3);
    check("ovf_w0",    32'(got_q[0]),     32'h1122);
    check("ovf_w1",    32'(got_q[1]),     32'h3344);
    check("ovf_w2",    32'(got_q[2]),     32'h5566);
    check("ovf_sticky", 32'(o_overflow),  32'd1);

    // Full FIFO and last-beat pop in the same cycle: push refused, then taken.
    got_q.delete();
    drive(1'b1, 8'h2B, 8'h1A, 1'b0); tick();
    drive(1'b1, 8'h4D, 8'h3C, 1'b0); tick();
    drive(1'b1, 8'h6F, 8'h5E, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b1);
    wait_for_idx(7);
    check("fpp_full", 32'(o_count), 32'd2);
    drive(1'b1, 8'h99, 8'h90, 1'b1);
    tick();
    check("fpp_count_after_pop", 32'(o_count), 32'd1);
    tick();
    check("fpp_count_after_push", 32'(o_count), 32'd2);
    drain();
    check("fpp_words", 32'(got_q.size()), 32'd4);
    check("fpp_w0",    32'(got_q[0]),     32'h1A2B);
    check("fpp_w3",    32'(got_q[3]),     32'h9099);

    // Reset in the middle of a word.
    got_q.delete();
    drive(1'b1, 8'hF0, 8'h0F, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    wait_for_idx(4);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check("rst_valid", 32'(o_bit_valid), 32'd0);
    check("rst_count", 32'(o_count),     32'd0);
    check("rst_ovf",   32'(o_overflow),  32'd0);
    check("rst_idx",   32'(o_idx),       32'd0);
    drive(1'b1, 8'hC3, 8'h5A, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check("rst_new_idx", 32'(o_idx), 32'd0);
    drain();
    check("rst_words", 32'(got_q.size()), 32'd1);
    check("rst_word",  32'(got_q[0]),     32'h5AC3);

    // Randomized traffic with occasional resets.
    repeat (400) begin
      i_rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 3) == 0, SIZE'($urandom), SIZE'($urandom),
            $urandom_range(0, 3) != 0);
      tick();
    end
    i_rst_n = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
